// File: rtl/merge_arbiter_pkg.sv
// Shared constants for the 2:1 write-back merge arbiter.
// Source tags name which producer a merged word came from.
package merge_arbiter_pkg;

  localparam int   DATA_W_DFLT = 16;
  localparam logic SRC_IN0     = 1'b0;
  localparam logic SRC_IN1     = 1'b1;

endpackage

// File: rtl/merge_arbiter.sv
// Round-robin 2:1 merge onto the write-back bus.
// One-entry registered holding stage with a source tag per word.
module merge_arbiter
  import merge_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              r_valid;
  logic              r_src;
  logic              r_last;
  logic [DATA_W-1:0] r_data;

  logic w_free;
  logic w_open;
  logic w_g0;
  logic w_g1;

  // rst_n gates the grant so nothing is offered while reset is held
  always_comb begin
    w_free = ~r_valid | out_ready;
    w_open = en & rst_n & w_free;
    w_g0   = 1'b0;
    w_g1   = 1'b0;
    if (w_open) begin
      unique case (1'b1)
        in0_valid & in1_valid: begin
          w_g0 = (r_last == SRC_IN1);
          w_g1 = (r_last == SRC_IN0);
        end
        in0_valid & ~in1_valid: w_g0 = 1'b1;
        ~in0_valid & in1_valid: w_g1 = 1'b1;
        default: begin
          w_g0 = 1'b0;
          w_g1 = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= SRC_IN0;
      r_last  <= SRC_IN1;
    end else if (w_g0 | w_g1) begin
      r_valid <= 1'b1;
      r_data  <= w_g1 ? in1_data : in0_data;
      r_src   <= w_g1 ? SRC_IN1 : SRC_IN0;
      r_last  <= w_g1 ? SRC_IN1 : SRC_IN0;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in0_ready = w_g0;
  assign in1_ready = w_g1;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_merge_arbiter.sv
// Bench for merge_arbiter: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_merge_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] in0_data;
  logic        in0_valid;
  logic        in0_ready;
  logic [15:0] in1_data;
  logic        in1_valid;
  logic        in1_ready;
  logic [15:0] out_data;
  logic        out_src;
  logic        out_valid;
  logic        out_ready;

  int n_pass = 0;
  int n_tot  = 0;

  merge_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [15:0] data;
  } word_t;

  // Reference: the holding slot is a queue of at most one word
  word_t hq[$];
  logic  m_last;

  function automatic logic [1:0] exp_rdy();
    logic free;
    free = (hq.size() == 0) || out_ready;
    if (!(en && rst_n && free)) return 2'b00;
    if (in0_valid && in1_valid) return m_last ? 2'b01 : 2'b10;
    if (in0_valid) return 2'b01;
    if (in1_valid) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] r;
    if (!rst_n) begin
      hq.delete();
      m_last <= 1'b1;
    end else begin
      r = exp_rdy();
      if (hq.size() != 0 && out_ready) void'(hq.pop_front());
      if (r != 2'b00) begin
        hq.push_back({r[1], r[1] ? in1_data : in0_data});
        m_last <= r[1];
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    logic [1:0] r;
    r = exp_rdy();
    chk("m_rdy0", {15'd0, in0_ready}, {15'd0, r[0]});
    chk("m_rdy1", {15'd0, in1_ready}, {15'd0, r[1]});
    chk("m_valid", {15'd0, out_valid}, {15'd0, hq.size() != 0});
    if (hq.size() != 0) begin
      chk("m_data", out_data, hq[0].data);
      chk("m_src", {15'd0, out_src}, {15'd0, hq[0].src});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [15:0] d,
                         input logic s);
    chk({nm, "_v"}, {15'd0, out_valid}, 16'd1);
    chk({nm, "_d"}, out_data, d);
    chk({nm, "_s"}, {15'd0, out_src}, {15'd0, s});
  endtask

  logic [15:0] tie_d[4];
  logic        tie_s[4];

  initial begin
    tie_d = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    tie_s = '{1'b0, 1'b1, 1'b0, 1'b1};

    // 1: reset with in0 already valid
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 16'h1234;
    in1_valid = 1'b0; in1_data = 16'h0000;
    #2;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_rdy0", {15'd0, in0_ready}, 16'd0);
    chk("rst_data", out_data, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rel_rdy0", {15'd0, in0_ready}, 16'd1);
    tick();
    in0_valid = 1'b0;
    chk_out("t1", 16'h1234, 1'b0);

    // one in1 word so the next tie favours in0
    in1_valid = 1'b1; in1_data = 16'h1111;
    tick();
    chk_out("pre", 16'h1111, 1'b1);

    // 2: tie round-robin
    in0_valid = 1'b1; in0_data = 16'hAAAA;
    in1_valid = 1'b1; in1_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("tie", tie_d[i], tie_s[i]);
    end
    in1_valid = 1'b0;

    // 3: backpressure
    in0_data = 16'h0F0F;
    tick();
    chk_out("bp0", 16'h0F0F, 1'b0);
    out_ready = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy0", {15'd0, in0_ready}, 16'd0);
      chk("bp_rdy1", {15'd0, in1_ready}, 16'd0);
      tick();
      chk_out("bp_hold", 16'h0F0F, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy1", {15'd0, in1_ready}, 16'd1);
    tick();
    in1_valid = 1'b0;
    chk_out("bp_new", 16'h2222, 1'b1);

    // 4: enable low drains, accepts nothing
    in0_valid = 1'b1; in0_data = 16'h0001;
    tick();
    in0_valid = 1'b0;
    chk_out("en_held", 16'h0001, 1'b0);
    en = 1'b0;
    in1_valid = 1'b1; in1_data = 16'hBEEF;
    #1;
    chk("en_rdy1", {15'd0, in1_ready}, 16'd0);
    tick();
    chk("en_drain", {15'd0, out_valid}, 16'd0);
    chk("en_rdy1b", {15'd0, in1_ready}, 16'd0);
    tick();
    chk("en_idle", {15'd0, out_valid}, 16'd0);
    en = 1'b1;
    #1;
    chk("en_rdy1c", {15'd0, in1_ready}, 16'd1);
    tick();
    in1_valid = 1'b0;
    chk_out("en_beef", 16'hBEEF, 1'b1);

    // 5: async reset between edges
    in0_valid = 1'b1; in0_data = 16'hCAFE;
    tick();
    in0_valid = 1'b0;
    chk_out("ar_cafe", 16'hCAFE, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {15'd0, out_valid}, 16'd0);
    chk("ar_data", out_data, 16'h0000);
    rst_n = 1'b1;
    in0_valid = 1'b1; in0_data = 16'h3333;
    in1_valid = 1'b1; in1_data = 16'h4444;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk_out("ar_tie", 16'h3333, 1'b0);

    // 6: full-rate stream from in0
    in0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in0_data = 16'(i);
      tick();
      chk_out("tp", 16'(i), 1'b0);
    end
    in0_valid = 1'b0;
    tick();
    chk("tp_end", {15'd0, out_valid}, 16'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
